// File: rtl/wb_arbiter_pkg.sv
// Shared widths, grant encoding and helpers for the writeback arbiter.
package wb_arbiter_pkg;

   localparam int WB_XLEN    = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Which source owns the regfile write port this cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_EX   = 2'd1,
      GNT_LL   = 2'd2
   } gnt_src_e;

   // One-hot decode of a destination register index.
   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] oh;
      oh     = '0;
      oh[rd] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order sync FIFO for long-latency writeback entries. Exposes every slot
// plus a per-slot valid so the parent can build a destination mask.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 69
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH*WIDTH-1:0]   entries,
   output logic [DEPTH-1:0]         entry_vld
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;
   logic             do_push, do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rptr];

   // Pointers wrap naturally (DEPTH is a power of two); occupancy tracked separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_W'(1);
         if (do_pop)  rptr <= rptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is data-only; validity comes from pointers/count, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [PTR_W-1:0] off;
      assign off                       = PTR_W'(i) - rptr;
      assign entry_vld[i]              = ({1'b0, off} < count);
      assign entries[i*WIDTH +: WIDTH] = mem[i];
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order execute results with buffered long-latency
// results onto the single regfile write port, with an anti-starvation override.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN         = WB_XLEN,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [XLEN-1:0]       ex_wdata,
   output logic                  ex_ready,
   input  logic                  ll_valid,
   input  logic [REG_ADDR_W-1:0] ll_rd,
   input  logic [XLEN-1:0]       ll_wdata,
   output logic                  ll_ready,
   output logic                  wb_we,
   output logic [REG_ADDR_W-1:0] wb_waddr,
   output logic [XLEN-1:0]       wb_wdata,
   output logic [NUM_REGS-1:0]   pending_mask,
   output logic [63:0]           wb_cnt
);

   localparam int ENT_W = REG_ADDR_W + XLEN;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_full, fifo_empty;
   logic [ENT_W-1:0]       fifo_head;
   logic [DEPTH*ENT_W-1:0] fifo_entries;
   logic [DEPTH-1:0]       fifo_vld;
   logic [ST_W-1:0]        starve_cnt;
   logic                   override, push, pop;
   gnt_src_e               gnt;

   // Head has waited long enough: it takes the port ahead of execute.
   assign override = (fifo_count != '0) && (starve_cnt == ST_W'(STARVE_LIMIT));
   assign ex_ready = !override;
   assign ll_ready = !fifo_full;

   // rd==0 results complete their handshake but are never stored.
   assign push = ll_valid && ll_ready && (ll_rd != '0);
   assign pop  = (gnt == GNT_LL);

   wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({ll_rd, ll_wdata}),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .entries   (fifo_entries),
      .entry_vld (fifo_vld)
   );

   // Grant priority: override, then execute (rd!=0), then FIFO drain.
   always_comb begin
      gnt = GNT_NONE;
      if (override)
         gnt = GNT_LL;
      else if (ex_valid && ex_ready && (ex_rd != '0))
         gnt = GNT_EX;
      else if (!fifo_empty)
         gnt = GNT_LL;
   end

   // Starvation counter: reset on empty or pop, else saturating count-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (fifo_empty || pop)
         starve_cnt <= '0;
      else if (starve_cnt != ST_W'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + ST_W'(1);
   end

   // Registered write port; address/data hold when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we    <= 1'b0;
         wb_waddr <= '0;
         wb_wdata <= '0;
      end else begin
         wb_we <= (gnt != GNT_NONE);
         case (gnt)
            GNT_EX: begin
               wb_waddr <= ex_rd;
               wb_wdata <= ex_wdata;
            end
            GNT_LL: begin
               wb_waddr <= fifo_head[ENT_W-1 -: REG_ADDR_W];
               wb_wdata <= fifo_head[XLEN-1:0];
            end
            default: ;
         endcase
      end
   end

   // Commit counter: one per issued regfile write, wraps at 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wb_cnt <= '0;
      else
         wb_cnt <= wb_cnt + 64'(wb_we);
   end

   // Destinations still held in the FIFO; x0 is never a hazard.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (fifo_vld[i])
            pending_mask = pending_mask |
                           rd_onehot(fifo_entries[i*ENT_W + XLEN +: REG_ADDR_W]);
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-cycle vector tables check the
// handshake/mask outputs, and the writes each row should cause are queued
// and matched against the registered write port one cycle later.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ll_valid;
   logic [4:0]  ex_rd, ll_rd;
   logic [63:0] ex_wdata, ll_wdata;
   logic        ex_ready, ll_ready;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [63:0] wb_wdata;
   logic [31:0] pending_mask;
   logic [63:0] wb_cnt;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(64), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_wdata     (ex_wdata),
      .ex_ready     (ex_ready),
      .ll_valid     (ll_valid),
      .ll_rd        (ll_rd),
      .ll_wdata     (ll_wdata),
      .ll_ready     (ll_ready),
      .wb_we        (wb_we),
      .wb_waddr     (wb_waddr),
      .wb_wdata     (wb_wdata),
      .pending_mask (pending_mask),
      .wb_cnt       (wb_cnt)
   );

   typedef struct {
      logic        exv;
      logic [4:0]  exrd;
      logic [63:0] exd;
      logic        llv;
      logic [4:0]  llrd;
      logic [63:0] lld;
      logic        e_exr;
      logic        e_llr;
      logic [31:0] e_pm;
      logic        wr;
      logic [4:0]  wrd;
      logic [63:0] wd;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] d;
   } wr_t;

   vec_t        vq[$];
   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   longint unsigned seen_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t V(input logic exv, input logic [4:0] exrd, input logic [63:0] exd,
                              input logic llv, input logic [4:0] llrd, input logic [63:0] lld,
                              input logic exr, input logic llr, input logic [31:0] pm,
                              input logic wr, input logic [4:0] wrd, input logic [63:0] wd);
      vec_t r;
      r = '{exv, exrd, exd, llv, llrd, lld, exr, llr, pm, wr, wrd, wd};
      return r;
   endfunction

   // Write-port monitor: pops the scoreboard on every write, tracks wb_cnt.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         seen_cnt = 0;
      end else begin
         chk("wb_cnt", wb_cnt, seen_cnt);
         if (wb_we) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL write: got x%0d=0x%0h expected no write", wb_waddr, wb_wdata);
            end else begin : pop_blk
               wr_t e;
               e = exp_q.pop_front();
               chk("wb_waddr", 64'(wb_waddr), 64'(e.rd));
               chk("wb_wdata", wb_wdata, e.d);
            end
            seen_cnt++;
         end
      end
   end

   // Apply queued rows one cycle each; check ready/mask, queue expected writes.
   task automatic run_vecs(input string tag);
      foreach (vq[k]) begin
         ex_valid = vq[k].exv;  ex_rd = vq[k].exrd;  ex_wdata = vq[k].exd;
         ll_valid = vq[k].llv;  ll_rd = vq[k].llrd;  ll_wdata = vq[k].lld;
         chk($sformatf("%s[%0d].ex_ready", tag, k), 64'(ex_ready), 64'(vq[k].e_exr));
         chk($sformatf("%s[%0d].ll_ready", tag, k), 64'(ll_ready), 64'(vq[k].e_llr));
         chk($sformatf("%s[%0d].pending_mask", tag, k), 64'(pending_mask), 64'(vq[k].e_pm));
         if (vq[k].wr) exp_q.push_back('{vq[k].wrd, vq[k].wd});
         @(posedge clk);
         #1;
      end
      vq.delete();
   endtask

   task automatic idle_rows(input int n);
      for (int i = 0; i < n; i++)
         vq.push_back(V(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0));
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid = 0; ex_rd = 0; ex_wdata = 0;
      ll_valid = 0; ll_rd = 0; ll_wdata = 0;
      #3;
      chk("reset.wb_we", 64'(wb_we), 0);
      chk("reset.wb_waddr", 64'(wb_waddr), 0);
      chk("reset.wb_wdata", wb_wdata, 0);
      chk("reset.wb_cnt", wb_cnt, 0);
      chk("reset.pending_mask", 64'(pending_mask), 0);
      chk("reset.ll_ready", 64'(ll_ready), 1);
      chk("reset.ex_ready", 64'(ex_ready), 1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-stream with three FIFO entries held back by execute traffic.
      vq.push_back(V(1, 9, 64'h901, 1, 1, 64'hA1, 1, 1, 32'h0, 1, 9, 64'h901));
      vq.push_back(V(1, 9, 64'h902, 1, 2, 64'hA2, 1, 1, 32'h2, 1, 9, 64'h902));
      vq.push_back(V(1, 9, 64'h903, 1, 3, 64'hA3, 1, 1, 32'h6, 1, 9, 64'h903));
      run_vecs("rst_mid");
      ex_valid = 0; ll_valid = 0;
      chk("rst_mid.pre_mask", 64'(pending_mask), 64'hE);
      chk("rst_mid.pre_ll_ready", 64'(ll_ready), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid.wb_we", 64'(wb_we), 0);
      chk("rst_mid.pending_mask", 64'(pending_mask), 0);
      chk("rst_mid.ll_ready", 64'(ll_ready), 1);
      chk("rst_mid.wb_cnt", wb_cnt, 0);
      chk("rst_mid.wb_waddr", 64'(wb_waddr), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      idle_rows(4);
      run_vecs("rst_after");

      // Execute only: x5 written, rd=0 dropped.
      vq.push_back(V(1, 5, 64'hDEAD, 0, 0, 0, 1, 1, 32'h0, 1, 5, 64'hDEAD));
      vq.push_back(V(1, 0, 64'h1,    0, 0, 0, 1, 1, 32'h0, 0, 0, 0));
      idle_rows(1);
      run_vecs("ex_only");
      chk("ex_only.wb_cnt", wb_cnt, 1);

      // Contention: FIFO head overrides execute after 8 waiting cycles.
      vq.push_back(V(1, 1, 64'h100, 1, 7, 64'h77, 1, 1, 32'h0, 1, 1, 64'h100));
      for (int k = 1; k <= 8; k++)
         vq.push_back(V(1, 1, 64'h100 + 64'(k), 0, 0, 0, 1, 1, 32'h80, 1, 1, 64'h100 + 64'(k)));
      vq.push_back(V(1, 1, 64'h109, 0, 0, 0, 0, 1, 32'h80, 1, 7, 64'h77));
      vq.push_back(V(1, 1, 64'h109, 0, 0, 0, 1, 1, 32'h0,  1, 1, 64'h109));
      idle_rows(1);
      run_vecs("starve");

      // FIFO full under execute pressure, then in-order drain.
      vq.push_back(V(1, 9, 64'h900, 1, 1, 64'hC1, 1, 1, 32'h00, 1, 9, 64'h900));
      vq.push_back(V(1, 9, 64'h901, 1, 2, 64'hC2, 1, 1, 32'h02, 1, 9, 64'h901));
      vq.push_back(V(1, 9, 64'h902, 1, 3, 64'hC3, 1, 1, 32'h06, 1, 9, 64'h902));
      vq.push_back(V(1, 9, 64'h903, 1, 4, 64'hC4, 1, 1, 32'h0E, 1, 9, 64'h903));
      for (int k = 4; k <= 8; k++)
         vq.push_back(V(1, 9, 64'h900 + 64'(k), 1, 5, 64'hC5, 1, 0, 32'h1E, 1, 9, 64'h900 + 64'(k)));
      vq.push_back(V(1, 9, 64'h909, 1, 5, 64'hC5, 0, 0, 32'h1E, 1, 1, 64'hC1));
      vq.push_back(V(1, 9, 64'h909, 1, 5, 64'hC5, 1, 1, 32'h1C, 1, 9, 64'h909));
      vq.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 32'h3C, 1, 2, 64'hC2));
      vq.push_back(V(0, 0, 0, 0, 0, 0, 1, 1, 32'h38, 1, 3, 64'hC3));
      vq.push_back(V(0, 0, 0, 0, 0, 0, 1, 1, 32'h30, 1, 4, 64'hC4));
      vq.push_back(V(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1, 5, 64'hC5));
      idle_rows(1);
      run_vecs("full");

      // Idle drain with push and pop in the same cycle.
      vq.push_back(V(0, 0, 0, 1, 10, 64'hD0, 1, 1, 32'h0,    0, 0,  0));
      vq.push_back(V(0, 0, 0, 1, 11, 64'hD1, 1, 1, 32'h400,  1, 10, 64'hD0));
      vq.push_back(V(0, 0, 0, 1, 12, 64'hD2, 1, 1, 32'h800,  1, 11, 64'hD1));
      vq.push_back(V(0, 0, 0, 0, 0,  0,      1, 1, 32'h1000, 1, 12, 64'hD2));
      idle_rows(1);
      run_vecs("drain");

      // rd=0 results from either source are accepted and dropped.
      vq.push_back(V(0, 0, 0,     1, 0,  64'hBAD, 1, 1, 32'h0,    0, 0,  0));
      vq.push_back(V(1, 0, 64'h55, 1, 13, 64'hE13, 1, 1, 32'h0,   0, 0,  0));
      vq.push_back(V(1, 0, 64'h55, 1, 0,  64'hBAD, 1, 1, 32'h2000, 1, 13, 64'hE13));
      idle_rows(2);
      run_vecs("rd0");

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
